// File: rtl/ray_gen.sv
// Camera ray generator: walks a width x height raster row-major and writes one ray per pixel
// into a FIFO (out_wr_en/out_full). Optional pixel tags on out_px/out_py under RAY_GEN_PIXEL_TAG_EN.
module ray_gen #(
    parameter int D_BITS = 32,
    parameter int Q_BITS = 16,
    parameter int W_BITS = 10,
    parameter int H_BITS = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [W_BITS-1:0]      width,
    input  logic [H_BITS-1:0]      height,
    input  logic [2:0][D_BITS-1:0] cam_origin,
    input  logic [2:0][D_BITS-1:0] dir_base,
    input  logic [2:0][D_BITS-1:0] step_x,
    input  logic [2:0][D_BITS-1:0] step_y,
    input  logic                   out_full,
    output logic                   out_wr_en,
    output logic [2:0][D_BITS-1:0] origin,
    output logic [2:0][D_BITS-1:0] dir,
    output logic                   busy,
    output logic                   done,
`ifdef RAY_GEN_PIXEL_TAG_EN
    output logic [W_BITS-1:0]      out_px,
    output logic [H_BITS-1:0]      out_py,
`endif
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W_BITS-1:0] W_ONE = W_BITS'(1);
    localparam logic [H_BITS-1:0] H_ONE = H_BITS'(1);

    // Q_BITS only documents the fixed-point format; every operation is a plain wrapping add.
    if (Q_BITS < 0 || Q_BITS >= D_BITS) begin : g_bad_q_bits
        $error("Q_BITS must lie in [0, D_BITS)");
    end

    state_t                   state;
    logic [W_BITS-1:0]        px;
    logic [H_BITS-1:0]        py;
    logic [W_BITS-1:0]        width_q;
    logic [H_BITS-1:0]        height_q;
    logic [2:0][D_BITS-1:0]   origin_q;
    logic [2:0][D_BITS-1:0]   step_x_q;
    logic [2:0][D_BITS-1:0]   step_y_q;
    logic [2:0][D_BITS-1:0]   cur_dir;
    logic [2:0][D_BITS-1:0]   row_dir;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            px       <= '0;
            py       <= '0;
            width_q  <= '0;
            height_q <= '0;
            origin_q <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
            cur_dir  <= '0;
            row_dir  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        width_q  <= width;
                        height_q <= height;
                        origin_q <= cam_origin;
                        step_x_q <= step_x;
                        step_y_q <= step_y;
                        cur_dir  <= dir_base;
                        row_dir  <= dir_base;
                        px       <= '0;
                        py       <= '0;
                        state    <= (width == '0 || height == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // A write happens exactly when out_full is low; otherwise everything holds.
                    if (!out_full) begin
                        if (px != width_q - W_ONE) begin
                            px <= px + W_ONE;
                            for (int i = 0; i < 3; i++) begin
                                cur_dir[i] <= cur_dir[i] + step_x_q[i];
                            end
                        end else if (py != height_q - H_ONE) begin
                            px <= '0;
                            py <= py + H_ONE;
                            // Each component adds separately so carries never cross x/y/z.
                            for (int i = 0; i < 3; i++) begin
                                row_dir[i] <= row_dir[i] + step_y_q[i];
                                cur_dir[i] <= row_dir[i] + step_y_q[i];
                            end
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state only; the data path is zero outside RUN.
    assign out_wr_en = (state == RUN) && !out_full;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign origin    = (state == RUN) ? origin_q : '0;
    assign dir       = (state == RUN) ? cur_dir : '0;
    assign state_dbg = state;

`ifdef RAY_GEN_PIXEL_TAG_EN
    assign out_px = px;
    assign out_py = py;
`endif

endmodule

// File: tb/tb_ray_gen.sv
// Directed bench for ray_gen: basic frame, backpressure, zero size, reset mid-frame,
// wrap-around, degenerate rasters and (when RAY_GEN_PIXEL_TAG_EN is defined) pixel tags.
module tb_ray_gen;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [9:0]        width;
    logic [9:0]        height;
    logic [2:0][31:0]  cam_origin;
    logic [2:0][31:0]  dir_base;
    logic [2:0][31:0]  step_x;
    logic [2:0][31:0]  step_y;
    logic              out_full;
    logic              out_wr_en;
    logic [2:0][31:0]  origin;
    logic [2:0][31:0]  dir;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;
`ifdef RAY_GEN_PIXEL_TAG_EN
    logic [9:0]        out_px;
    logic [9:0]        out_py;
`endif

    int checks = 0;
    int errors = 0;
    logic [95:0] exp_q[$];
    logic [19:0] tag_q[$];

    ray_gen dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .width      (width),
        .height     (height),
        .cam_origin (cam_origin),
        .dir_base   (dir_base),
        .step_x     (step_x),
        .step_y     (step_y),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .origin     (origin),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
`ifdef RAY_GEN_PIXEL_TAG_EN
        .out_px     (out_px),
        .out_py     (out_py),
`endif
        .state_dbg  (state_dbg)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return {z, y, x};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_v(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model for generated frames: dir = base + px*sx + py*sy, per component, 32-bit wrap.
    task automatic push_model(input int w, input int h);
        logic [2:0][31:0] e;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                for (int i = 0; i < 3; i++) begin
                    e[i] = dir_base[i] + 32'(x) * step_x[i] + 32'(y) * step_y[i];
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_tags(input int w, input int h);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                tag_q.push_back({10'(y), 10'(x)});
            end
        end
    endtask

    // Driver: pulse start for one edge, then scramble inputs to prove they were latched.
    task automatic start_frame(input int w, input int h);
        width  = 10'(w);
        height = 10'(h);
        start  = 1'b1;
        cyc();
        start      = 1'b0;
        width      = 10'($urandom_range(0, 1023));
        height     = 10'($urandom_range(0, 1023));
        cam_origin = {$urandom(), $urandom(), $urandom()};
        dir_base   = {$urandom(), $urandom(), $urandom()};
        step_x     = {$urandom(), $urandom(), $urandom()};
        step_y     = {$urandom(), $urandom(), $urandom()};
    endtask

    // Scoreboard: one observed write against the head of the expected queues.
    task automatic take_write(input string tag, input logic [95:0] org);
        logic [95:0] e;
        logic [19:0] t;
        e = 'x;
        t = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        if (tag_q.size() != 0) t = tag_q.pop_front();
        check_v({tag, "_dir"}, dir, e);
        check_v({tag, "_origin"}, origin, org);
        check_b({tag, "_busy"}, busy, 1'b1);
`ifdef RAY_GEN_PIXEL_TAG_EN
        check_i({tag, "_px"}, int'(out_px), int'(t[9:0]));
        check_i({tag, "_py"}, int'(out_py), int'(t[19:10]));
`endif
    endtask

    // Runs a started frame to its done pulse, optionally stalling stall_len cycles after stall_after writes.
    task automatic drain(input string tag, input int n, input int stall_after,
                         input int stall_len, input logic [95:0] org);
        int writes;
        int c;
        int stalled;
        writes  = 0;
        c       = 0;
        stalled = 0;
        while (c < 100) begin
            out_full = (writes == stall_after && stalled < stall_len);
            #1;
            if (done) break;
            if (out_full) begin
                check_b({tag, "_stall_wren"}, out_wr_en, 1'b0);
                check_v({tag, "_stall_dir"}, dir, (exp_q.size() != 0) ? exp_q[0] : 96'hx);
                stalled++;
            end else begin
                check_b({tag, "_wren"}, out_wr_en, 1'b1);
                if (out_wr_en) begin
                    take_write(tag, org);
                    writes++;
                end
            end
            cyc();
            c++;
        end
        out_full = 1'b0;
        check_b({tag, "_done_seen"}, done, 1'b1);
        check_i({tag, "_writes"}, writes, n);
        check_i({tag, "_done_cycle"}, c, n + stall_len);
        check_b({tag, "_done_wren"}, out_wr_en, 1'b0);
        check_b({tag, "_done_busy"}, busy, 1'b0);
        check_i({tag, "_leftover"}, exp_q.size(), 0);
        cyc();
        check_b({tag, "_done_pulse"}, done, 1'b0);
        check_b({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [95:0] org;
        int writes;

        reset      = 1'b1;
        start      = 1'b0;
        width      = '0;
        height     = '0;
        cam_origin = '0;
        dir_base   = '0;
        step_x     = '0;
        step_y     = '0;
        out_full   = 1'b0;
        repeat (3) cyc();
        check_b("rst_wren", out_wr_en, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_done", done, 1'b0);
        check_v("rst_dir", dir, '0);
        check_v("rst_origin", origin, '0);
`ifdef RAY_GEN_PIXEL_TAG_EN
        check_i("rst_px", int'(out_px), 0);
        check_i("rst_py", int'(out_py), 0);
`endif
        reset = 1'b0;
        cyc();

        // Basic 2x2 frame
        cam_origin = v3(32'h0, 32'h0, 32'hFFFB0000);
        dir_base   = v3(32'hFFFF0000, 32'h00010000, 32'h00010000);
        step_x     = v3(32'h00010000, 32'h0, 32'h0);
        step_y     = v3(32'h0, 32'hFFFF0000, 32'h0);
        org = cam_origin;
        exp_q.push_back(v3(32'hFFFF0000, 32'h00010000, 32'h00010000));
        exp_q.push_back(v3(32'h00000000, 32'h00010000, 32'h00010000));
        exp_q.push_back(v3(32'hFFFF0000, 32'h00000000, 32'h00010000));
        exp_q.push_back(v3(32'h00000000, 32'h00000000, 32'h00010000));
        push_tags(2, 2);
        start_frame(2, 2);
        drain("basic", 4, -1, 0, org);

        // Same frame with 3 full cycles after the 2nd write
        cam_origin = v3(32'h0, 32'h0, 32'hFFFB0000);
        dir_base   = v3(32'hFFFF0000, 32'h00010000, 32'h00010000);
        step_x     = v3(32'h00010000, 32'h0, 32'h0);
        step_y     = v3(32'h0, 32'hFFFF0000, 32'h0);
        exp_q.push_back(v3(32'hFFFF0000, 32'h00010000, 32'h00010000));
        exp_q.push_back(v3(32'h00000000, 32'h00010000, 32'h00010000));
        exp_q.push_back(v3(32'hFFFF0000, 32'h00000000, 32'h00010000));
        exp_q.push_back(v3(32'h00000000, 32'h00000000, 32'h00010000));
        push_tags(2, 2);
        start_frame(2, 2);
        drain("bp", 4, 2, 3, org);

        // Zero width
        width  = 10'd0;
        height = 10'd5;
        start  = 1'b1;
        cyc();
        start = 1'b0;
        check_b("zero_done", done, 1'b1);
        check_b("zero_busy", busy, 1'b0);
        check_b("zero_wren", out_wr_en, 1'b0);
        cyc();
        check_b("zero_done_end", done, 1'b0);
        check_b("zero_busy_end", busy, 1'b0);
        check_b("zero_wren_end", out_wr_en, 1'b0);

        // 4x4 frame: second start after write 3 is ignored, reset after write 5
        cam_origin = v3(32'h00000001, 32'h00000002, 32'h00000003);
        dir_base   = v3(32'h00010000, 32'h00020000, 32'h00030000);
        step_x     = v3(32'h00010000, 32'h0, 32'h0);
        step_y     = v3(32'h0, 32'h00010000, 32'h0);
        org = cam_origin;
        push_model(4, 4);
        push_tags(4, 4);
        start_frame(4, 4);
        writes = 0;
        for (int c = 0; c < 5; c++) begin
            check_b("f4_wren", out_wr_en, 1'b1);
            take_write("f4", org);
            writes++;
            start = (writes == 3);
            cyc();
        end
        start = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_b("mid_rst_wren", out_wr_en, 1'b0);
        check_b("mid_rst_busy", busy, 1'b0);
        check_b("mid_rst_done", done, 1'b0);
        check_v("mid_rst_dir", dir, '0);
        check_v("mid_rst_origin", origin, '0);
        cyc();
        check_b("mid_rst_quiet", out_wr_en, 1'b0);
        exp_q.delete();
        tag_q.delete();

        cam_origin = v3(32'h00000001, 32'h00000002, 32'h00000003);
        dir_base   = v3(32'h00010000, 32'h00020000, 32'h00030000);
        step_x     = v3(32'h00010000, 32'h0, 32'h0);
        step_y     = v3(32'h0, 32'h00010000, 32'h0);
        push_model(4, 4);
        push_tags(4, 4);
        start_frame(4, 4);
        drain("fresh", 16, -1, 0, org);

        // Wrap-around of x over 3x1
        cam_origin = v3(32'h0, 32'h0, 32'h0);
        dir_base   = v3(32'h7FFF0000, 32'h0, 32'h0);
        step_x     = v3(32'h00010000, 32'h0, 32'h0);
        step_y     = v3(32'h0, 32'h0, 32'h0);
        org = cam_origin;
        exp_q.push_back(v3(32'h7FFF0000, 32'h0, 32'h0));
        exp_q.push_back(v3(32'h80000000, 32'h0, 32'h0));
        exp_q.push_back(v3(32'h80010000, 32'h0, 32'h0));
        push_tags(3, 1);
        start_frame(3, 1);
        drain("wrap", 3, -1, 0, org);

        // Degenerate width=1: every write advances the row
        cam_origin = v3(32'h11111111, 32'h22222222, 32'h33333333);
        dir_base   = v3(32'h00000000, 32'h00050000, 32'hFFFF8000);
        step_x     = v3(32'h12345678, 32'h0, 32'h0);
        step_y     = v3(32'h00008000, 32'hFFFF0000, 32'h00000001);
        org = cam_origin;
        push_model(1, 3);
        push_tags(1, 3);
        start_frame(1, 3);
        drain("w1", 3, -1, 0, org);

        // 3x2 frame exercising pixel tags
        cam_origin = v3(32'hDEAD0000, 32'h0000BEEF, 32'h00000000);
        dir_base   = v3(32'hFFFE0000, 32'h00030000, 32'h0);
        step_x     = v3(32'h0, 32'h0, 32'h00008000);
        step_y     = v3(32'h00020000, 32'hFFFF0000, 32'h0);
        org = cam_origin;
        push_model(3, 2);
        push_tags(3, 2);
        start_frame(3, 2);
        drain("tag", 6, -1, 0, org);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
